// File: rtl/mm_seq_pkg.sv
// rtl/mm_seq_pkg.sv - shared state encoding and geometry for the MAC sequencer
package mm_seq_pkg;
   localparam int DW             = 8;
   localparam int NROW           = 4;
   localparam int NCOL           = 8;
   localparam int NOUT           = 4;
   localparam int ACCW           = 18;
   localparam int AW             = 4;
   localparam int RW             = DW * NCOL;
   localparam int KW             = $clog2(NROW * NCOL);
   localparam int COMPUTE_CYCLES = NCOL * NOUT;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_DRAIN,
      ST_FIN
   } state_t;
endpackage

// File: rtl/mm_row_buffer.sv
// rtl/mm_row_buffer.sv - four row registers with byte-addressed load and byte rotation
module mm_row_buffer
   import mm_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [KW-1:0] k,
   input  logic [DW-1:0] wdata,
   input  logic          rot,
   output logic [RW-1:0] row1,
   output logic [RW-1:0] row2,
   output logic [RW-1:0] row3,
   output logic [RW-1:0] row4
);
   logic [RW-1:0] row_q [NROW];
   logic [5:0]    lsb;

   // slot 0 sits in the top byte, so the bit offset is (7 - slot) * 8
   assign lsb = {~k[2:0], 3'b000};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NROW; i++) row_q[i] <= '0;
      end else if (we) begin
         row_q[k[KW-1:3]][lsb +: DW] <= wdata;
      end else if (rot) begin
         for (int i = 0; i < NROW; i++)
            row_q[i] <= {row_q[i][RW-DW-1:0], row_q[i][RW-1 -: DW]};
      end
   end

   assign row1 = row_q[0];
   assign row2 = row_q[1];
   assign row3 = row_q[2];
   assign row4 = row_q[3];
endmodule

// File: rtl/mm_seq_ctrl.sv
// rtl/mm_seq_ctrl.sv - load/compute/drain sequencer feeding the MAC ALU and result RAM
module mm_seq_ctrl
   import mm_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_data,
   output logic            in_ready,
   output logic            alu_en,
   output logic [RW-1:0]   x_row1,
   output logic [RW-1:0]   x_row2,
   output logic [RW-1:0]   x_row3,
   output logic [RW-1:0]   x_row4,
   input  logic [ACCW-1:0] alu_mu1,
   input  logic [ACCW-1:0] alu_mu2,
   input  logic [ACCW-1:0] alu_mu3,
   input  logic [ACCW-1:0] alu_mu4,
   input  logic            alu_web,
   input  logic            alu_done,
   output logic            ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [ACCW-1:0] ram_wdata,
   output logic            busy,
   output logic            done,
   output logic            err
);
   localparam logic [KW-1:0] K_LAST   = KW'(NROW * NCOL - 1);
   localparam logic [4:0]    CYC_LAST = 5'(COMPUTE_CYCLES - 1);
   localparam logic [2:0]    C_FULL   = 3'(NOUT);

   state_t          state, state_nxt;
   logic [KW-1:0]   k_q;
   logic [4:0]      cyc_q;
   logic [2:0]      c_q;
   logic [1:0]      r_q;
   logic            burst_q;
   logic            done_seen_q;
   logic            err_q;
   logic [ACCW-1:0] hold_q [NROW];

   logic accept;
   logic capture_win;
   logic web_ok;

   assign accept      = (state == ST_LOAD) && in_valid;
   assign capture_win = (state == ST_COMPUTE) || (state == ST_DRAIN);
   // a column is taken only when the serialiser is free and RAM space remains
   assign web_ok      = capture_win && alu_web && !burst_q && (c_q != C_FULL);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      alu_en    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (accept && (k_q == K_LAST)) state_nxt = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            alu_en = 1'b1;
            if (cyc_q == CYC_LAST) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!burst_q && (c_q == C_FULL)) state_nxt = ST_FIN;
         end
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         k_q         <= '0;
         cyc_q       <= '0;
         c_q         <= '0;
         r_q         <= '0;
         burst_q     <= 1'b0;
         done_seen_q <= 1'b0;
         err_q       <= 1'b0;
         for (int i = 0; i < NROW; i++) hold_q[i] <= '0;
      end else begin
         state <= state_nxt;

         if ((state == ST_IDLE) && start) begin
            k_q         <= '0;
            cyc_q       <= '0;
            c_q         <= '0;
            r_q         <= '0;
            burst_q     <= 1'b0;
            done_seen_q <= 1'b0;
            err_q       <= 1'b0;
         end

         if (accept && (k_q != K_LAST)) k_q <= k_q + 1'b1;
         if ((state == ST_COMPUTE) && (cyc_q != CYC_LAST)) cyc_q <= cyc_q + 1'b1;

         if (web_ok) begin
            hold_q[0] <= alu_mu1;
            hold_q[1] <= alu_mu2;
            hold_q[2] <= alu_mu3;
            hold_q[3] <= alu_mu4;
            burst_q   <= 1'b1;
            r_q       <= '0;
         end else if (burst_q) begin
            if (r_q == 2'd3) begin
               burst_q <= 1'b0;
               r_q     <= '0;
               c_q     <= c_q + 1'b1;
            end else begin
               r_q <= r_q + 1'b1;
            end
         end

         if (capture_win && alu_web && !web_ok) err_q <= 1'b1;

         if (alu_done) begin
            if (capture_win) done_seen_q <= 1'b1;
            else             err_q       <= 1'b1;
         end

         // a pass-complete strobe arriving on the exit cycle still counts
         if ((state == ST_DRAIN) && (state_nxt == ST_FIN) && !(done_seen_q || alu_done))
            err_q <= 1'b1;
      end
   end

   assign ram_we    = burst_q;
   assign ram_addr  = {c_q[1:0], r_q};
   assign ram_wdata = hold_q[r_q];
   assign err       = err_q;

   mm_row_buffer u_rows (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .k     (k_q),
      .wdata (in_data),
      .rot   (alu_en),
      .row1  (x_row1),
      .row2  (x_row2),
      .row3  (x_row3),
      .row4  (x_row4)
   );
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb/tb_mm_seq_ctrl.sv - directed and randomized jobs checked against a matrix/RAM reference model
module tb_mm_seq_ctrl;
   import mm_seq_pkg::*;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic            in_valid = 1'b0;
   logic [7:0]      in_data = '0;
   logic            in_ready;
   logic            alu_en;
   logic [63:0]     x_row [4];
   logic [17:0]     mu [4];
   logic            alu_web = 1'b0;
   logic            alu_done = 1'b0;
   logic            ram_we;
   logic [3:0]      ram_addr;
   logic [17:0]     ram_wdata;
   logic            busy;
   logic            done;
   logic            err;

   int n_chk  = 0;
   int n_fail = 0;
   logic [21:0] ram_log [$];

   initial for (int i = 0; i < 4; i++) mu[i] = '0;

   mm_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .alu_en    (alu_en),
      .x_row1    (x_row[0]),
      .x_row2    (x_row[1]),
      .x_row3    (x_row[2]),
      .x_row4    (x_row[3]),
      .alu_mu1   (mu[0]),
      .alu_mu2   (mu[1]),
      .alu_mu3   (mu[2]),
      .alu_mu4   (mu[3]),
      .alu_web   (alu_web),
      .alu_done  (alu_done),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ram_we === 1'b1) ram_log.push_back({ram_addr, ram_wdata});

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
      int b;
      b = (n % 8) * 8;
      if (b == 0) return v;
      return (v << b) | (v >> (64 - b));
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 0);
      check({tag, "_alu_en"}, 64'(alu_en), 0);
      check({tag, "_ram_we"}, 64'(ram_we), 0);
      check({tag, "_ram_addr"}, 64'(ram_addr), 0);
      check({tag, "_ram_wdata"}, 64'(ram_wdata), 0);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_err"}, 64'(err), 0);
      for (int r = 0; r < 4; r++) check({tag, "_x_row"}, x_row[r], 0);
   endtask

   // mode: 0 = bytes 1..32 and mu = col*4+lane+1, 1 = random
   // stall: 0 = none, 1 = 1,0,0 repeating, 2 = random
   task automatic run_job(input int mode, input int stall, input bit extra_web, input int abort_at);
      logic [7:0]  mat [32];
      logic [63:0] exp_row [4];
      logic [21:0] exp_log [$];
      int idx, guard, ready_cnt, legit, last_ok;
      bit exp_err, v, web;

      for (int i = 0; i < 32; i++) mat[i] = (mode == 0) ? 8'(i + 1) : 8'($urandom);
      for (int r = 0; r < 4; r++) begin
         exp_row[r] = '0;
         for (int j = 0; j < 8; j++) exp_row[r] = {exp_row[r][55:0], mat[r*8+j]};
      end
      ram_log.delete();

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("err_after_start", 64'(err), 0);
      check("busy_in_load", 64'(busy), 1);

      idx = 0; guard = 0; ready_cnt = 0;
      while (idx < 32 && guard < 400) begin
         guard++;
         if (in_ready === 1'b1) ready_cnt++;
         case (stall)
            0:       v = 1'b1;
            1:       v = (guard % 3) == 1;
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data  = v ? mat[idx] : 8'($urandom);
         @(negedge clk);
         if (v) idx++;
      end
      in_valid = 1'b0;
      check("load_accepts", 64'(idx), 32);
      check("in_ready_cycles", 64'(ready_cnt), 64'(guard));
      check("in_ready_after_load", 64'(in_ready), 0);
      check("alu_en_after_load", 64'(alu_en), 1);

      legit = 0; last_ok = -100; exp_err = 1'b0;
      for (int cyc = 0; cyc < 32; cyc++) begin
         if (cyc == abort_at) begin
            alu_web = 1'b0; alu_done = 1'b0;
            rst = 1'b0;
            #1;
            check_all_zero("async_reset");
            @(negedge clk); rst = 1'b1;
            return;
         end
         check("alu_en_pass", 64'(alu_en), 1);
         for (int r = 0; r < 4; r++) check("x_row_rot", x_row[r], rotl(exp_row[r], cyc));
         web      = ((cyc % 8) == 7) || (extra_web && cyc == 9);
         alu_web  = web;
         alu_done = (cyc == 31);
         if (web) begin
            for (int l = 0; l < 4; l++) mu[l] = (mode == 0) ? 18'(legit*4 + l + 1) : 18'($urandom);
            // a column needs four free write cycles after the previous accepted one
            if (legit < 4 && cyc >= last_ok + 5) begin
               for (int l = 0; l < 4; l++) exp_log.push_back({4'(legit*4 + l), mu[l]});
               legit++;
               last_ok = cyc;
            end else begin
               exp_err = 1'b1;
            end
         end
         @(negedge clk);
      end
      alu_web = 1'b0; alu_done = 1'b0;
      check("alu_en_after_pass", 64'(alu_en), 0);
      check("x_row_after_pass", x_row[0], exp_row[0]);

      guard = 0;
      while (done !== 1'b1 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check("done_pulse", 64'(done), 1);
      check("err_at_done", 64'(err), 64'(exp_err));
      @(negedge clk);
      check("done_single", 64'(done), 0);
      check("busy_idle", 64'(busy), 0);
      check("err_sticky", 64'(err), 64'(exp_err));

      check("ram_write_count", 64'(ram_log.size()), 64'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < ram_log.size(); i++)
         check("ram_write", 64'(ram_log[i]), 64'(exp_log[i]));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      run_job(0, 0, 1'b0, -1);
      run_job(0, 1, 1'b0, -1);
      run_job(1, 2, 1'b1, -1);
      run_job(1, 2, 1'b0, -1);
      run_job(1, 0, 1'b0, 10);
      run_job(0, 0, 1'b0, -1);
      run_job(1, 2, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
